riscv_control_unit: RTL and testbench
=====================================

Name: riscv_control_unit

Overview:
- Multi-cycle control FSM that drives the single-cycle-free RV32I datapath: the command side of the datapath's control/status interface.
- Consumes the instruction register contents and branch comparator result.
- Sequences fetch, decode, execute, memory and writeback by asserting the datapath's enables and selects.
- Also keeps a retired-instruction counter.

Parameters:
- DWIDTH, 32, instruction/datapath width.
- CNT_WIDTH, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-low reset
- irOut  input  DWIDTH  current instruction from instruction register
- comparatorOut  input  1  branch condition result from comparator
- irEn  output  1  instruction register load enable
- pcEn  output  1  program counter update enable
- pcSelect  output  2  00 PC+4, 01 conditional PC+imm (PC block applies comparatorOut), 10 PC+imm (JAL), 11 ALU result (JALR)
- regWrite  output  1  register file write enable
- aluSrc  output  1  0 rs2, 1 immediate
- ramRdEn  output  1  data RAM read enable
- ramWrEn  output  1  data RAM write enable
- isByte, isHalf, isWord  output  1 each  one-hot access size
- memToReg  output  2  00 ALU, 01 RAM, 10 link (PC path), 11 immediate
- trap  output  1  illegal instruction seen (see Optional Feature)
- retireCount  output  CNT_WIDTH  instructions retired since reset

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Outputs are a Moore/decode function of state and irOut. irOut is stable from DECODE onward.
- Any output not listed for a state is 0.
- Reset:
  - reset low at a clock edge -> state=FETCH, retireCount=0.
  - All outputs forced 0 combinationally while reset is low.
  - Reset mid-instruction aborts it: no pcEn/regWrite/ramWrEn, no retire.
- FETCH: irEn=1; next DECODE.
- DECODE: no enables; opcode classified. Next state is EXEC, or TRAP for an illegal encoding.
- Opcode classes and EXEC behaviour:
  - R (0110011): aluSrc=0, regWrite=1, memToReg=00, pcEn=1, pcSelect=00; next FETCH.
  - I-ALU (0010011): same as R but aluSrc=1.
  - LUI (0110111): regWrite=1, memToReg=11, pcEn=1, pcSelect=00.
  - AUIPC (0010111): aluSrc=1, regWrite=1, memToReg=00, pcEn=1, pcSelect=00.
  - JAL (1101111): regWrite=1, memToReg=10, pcEn=1, pcSelect=10.
  - JALR (1100111): aluSrc=1, regWrite=1, memToReg=10, pcEn=1, pcSelect=11.
  - BRANCH (1100011): pcEn=1, pcSelect=01, regWrite=0.
  - LOAD (0000011): aluSrc=1 (address compute); next MEM.
  - STORE (0100011): aluSrc=1; next MEM.
- MEM (held aluSrc=1):
  - Load: ramRdEn=1; next WB.
  - Store: ramWrEn=1, pcEn=1, pcSelect=00; next FETCH.
- WB (load only): ramRdEn=1, aluSrc=1, regWrite=1, memToReg=01, pcEn=1, pcSelect=00; next FETCH.
- Size decode, driven in MEM and WB:
  - funct3[1:0]: 00 isByte, 01 isHalf, 10 isWord.
  - Load funct3 011/110/111 is illegal; store funct3 other than 000/001/010 is illegal.
- Latency (cycles incl. FETCH): ALU/LUI/AUIPC/JAL/JALR/BRANCH 3, STORE 4, LOAD 5.
- retireCount:
  - Increments by 1 on every edge where pcEn=1 and reset is high.
  - Wraps from all-ones to 0.
- Writes to x0 are not suppressed here (register file handles them).
- ramWrEn and regWrite are never both 1; ramRdEn and ramWrEn are never both 1.
- Illegal: unknown opcode, bad load/store funct3, or all-zero word.

Optional Feature:
- Macro CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - Illegal encoding in DECODE -> TRAP.
  - In TRAP, trap=1 and all other control outputs 0; retireCount frozen.
  - Stays in TRAP until reset low.
- Undefined:
  - Illegal encoding executes as NOP: EXEC with pcEn=1, pcSelect=00, no writes, counted as retired.
  - trap tied 0; TRAP state not built.

Test Plan:
- irOut=0x002081B3 (ADD x3,x1,x2) after reset -> cycle1 irEn=1; cycle3 regWrite=1, memToReg=00, aluSrc=0, pcEn=1, pcSelect=00; retireCount 0->1.
- irOut=0x0040A283 (LW x5,4(x1)) -> cycle4 ramRdEn=1, isWord=1, aluSrc=1; cycle5 regWrite=1, memToReg=01, pcEn=1; no ramWrEn ever.
- irOut=0x00208023 (SB x2,0(x1)) -> cycle4 ramWrEn=1, isByte=1, pcEn=1, pcSelect=00; regWrite=0 throughout.
- irOut=0x00208463 (BEQ x1,x2,+8), comparatorOut=0 then 1 -> cycle3 pcEn=1, pcSelect=01 in both runs, regWrite=0. irOut=0x010000EF (JAL x1,16) -> cycle3 regWrite=1, memToReg=10, pcSelect=10.
- irOut=0x00000000 -> with CTRL_ILLEGAL_TRAP_EN: trap=1 from cycle3, all enables 0 for 20 cycles, retireCount unchanged; without: pcEn=1, pcSelect=00 at cycle3, trap=0.
- LW started, reset driven low in MEM cycle -> that edge: no regWrite/pcEn, retireCount=0; reset high -> irEn=1 on next cycle (FETCH).

Source files
------------

// File: rtl/riscv_control_unit.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB and counts retired instructions.
// Optional macro CTRL_ILLEGAL_TRAP_EN: illegal encodings park the FSM in TRAP instead of running as NOP.
module riscv_control_unit #(
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DWIDTH-1:0]    irOut,
  input  logic                 comparatorOut,
  output logic                 irEn,
  output logic                 pcEn,
  output logic [1:0]           pcSelect,
  output logic                 regWrite,
  output logic                 aluSrc,
  output logic                 ramRdEn,
  output logic                 ramWrEn,
  output logic                 isByte,
  output logic                 isHalf,
  output logic                 isWord,
  output logic [1:0]           memToReg,
  output logic                 trap,
  output logic [CNT_WIDTH-1:0] retireCount
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  typedef enum logic [2:0] {
    FETCH, DECODE, EXEC, MEM, WB
`ifdef CTRL_ILLEGAL_TRAP_EN
    , TRAP
`endif
  } state_t;

  state_t                 state_reg, state_next;
  logic [CNT_WIDTH-1:0]   count_reg;
  logic [6:0]             opcode;
  logic [2:0]             funct3;
  logic                   is_load, is_store, known_op, illegal;
  logic                   ir_en, pc_en, reg_write, alu_src, ram_rd, ram_wr;
  logic                   is_byte, is_half, is_word, trap_c;
  logic [1:0]             pc_select, mem_to_reg;

  // The branch decision lives in the PC block; remaining IR bits are datapath-only.
  logic [DWIDTH-10:0]     unused_bits;
  assign unused_bits = {comparatorOut, irOut[DWIDTH-1:15], irOut[11:7]};

  assign opcode   = irOut[6:0];
  assign funct3   = irOut[14:12];
  assign is_load  = (opcode == OP_LOAD);
  assign is_store = (opcode == OP_STORE);
  assign known_op = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LUI) ||
                    (opcode == OP_AUIPC) || (opcode == OP_JAL) || (opcode == OP_JALR) ||
                    (opcode == OP_BRANCH) || is_load || is_store;
  assign illegal  = !known_op || (irOut == '0) ||
                    (is_load && ((funct3 == 3'b011) || (funct3[2:1] == 2'b11))) ||
                    (is_store && (funct3[2] || (funct3[1:0] == 2'b11)));

  always_comb begin
    state_next = state_reg;
    ir_en      = 1'b0;
    pc_en      = 1'b0;
    pc_select  = 2'b00;
    reg_write  = 1'b0;
    alu_src    = 1'b0;
    ram_rd     = 1'b0;
    ram_wr     = 1'b0;
    is_byte    = 1'b0;
    is_half    = 1'b0;
    is_word    = 1'b0;
    mem_to_reg = 2'b00;
    trap_c     = 1'b0;
    case (state_reg)
      FETCH: begin
        ir_en      = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
        state_next = illegal ? TRAP : EXEC;
`else
        state_next = EXEC;
`endif
      end
      EXEC: begin
        state_next = FETCH;
        if (illegal) begin
          pc_en = 1'b1;
        end else begin
          case (opcode)
            OP_R:      begin reg_write = 1'b1; pc_en = 1'b1; end
            OP_I:      begin alu_src = 1'b1; reg_write = 1'b1; pc_en = 1'b1; end
            OP_LUI:    begin reg_write = 1'b1; mem_to_reg = 2'b11; pc_en = 1'b1; end
            OP_AUIPC:  begin alu_src = 1'b1; reg_write = 1'b1; pc_en = 1'b1; end
            OP_JAL:    begin reg_write = 1'b1; mem_to_reg = 2'b10; pc_en = 1'b1; pc_select = 2'b10; end
            OP_JALR:   begin
              alu_src = 1'b1; reg_write = 1'b1; mem_to_reg = 2'b10; pc_en = 1'b1; pc_select = 2'b11;
            end
            OP_BRANCH: begin pc_en = 1'b1; pc_select = 2'b01; end
            default:   begin alu_src = 1'b1; state_next = MEM; end
          endcase
        end
      end
      MEM: begin
        alu_src = 1'b1;
        is_byte = (funct3[1:0] == 2'b00);
        is_half = (funct3[1:0] == 2'b01);
        is_word = (funct3[1:0] == 2'b10);
        if (is_load) begin
          ram_rd     = 1'b1;
          state_next = WB;
        end else begin
          ram_wr     = 1'b1;
          pc_en      = 1'b1;
          state_next = FETCH;
        end
      end
      WB: begin
        ram_rd     = 1'b1;
        alu_src    = 1'b1;
        reg_write  = 1'b1;
        mem_to_reg = 2'b01;
        pc_en      = 1'b1;
        is_byte    = (funct3[1:0] == 2'b00);
        is_half    = (funct3[1:0] == 2'b01);
        is_word    = (funct3[1:0] == 2'b10);
        state_next = FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      TRAP: trap_c = 1'b1;
`endif
      default: state_next = FETCH;
    endcase
  end

  // Everything is held at 0 while reset is low so an aborted instruction has no side effects.
  assign irEn        = reset & ir_en;
  assign pcEn        = reset & pc_en;
  assign pcSelect    = reset ? pc_select : 2'b00;
  assign regWrite    = reset & reg_write;
  assign aluSrc      = reset & alu_src;
  assign ramRdEn     = reset & ram_rd;
  assign ramWrEn     = reset & ram_wr;
  assign isByte      = reset & is_byte;
  assign isHalf      = reset & is_half;
  assign isWord      = reset & is_word;
  assign memToReg    = reset ? mem_to_reg : 2'b00;
  assign trap        = reset & trap_c;
  assign retireCount = reset ? count_reg : '0;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg <= FETCH;
      count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (pcEn) count_reg <= count_reg + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_riscv_control_unit.sv
// Self-checking bench for riscv_control_unit: directed test-plan steps plus random instructions vs a cycle-indexed model.
// Honours CTRL_ILLEGAL_TRAP_EN the same way the design does.
module tb_riscv_control_unit;
  localparam int CW = 4;  // small counter so wrap-around is exercised

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   irOut;
  logic          comparatorOut;
  logic          irEn, pcEn, regWrite, aluSrc, ramRdEn, ramWrEn, isByte, isHalf, isWord, trap;
  logic [1:0]    pcSelect, memToReg;
  logic [CW-1:0] retireCount;

  int checks = 0;
  int failures = 0;
  logic [CW-1:0] exp_count = '0;

  typedef struct packed {
    logic ir_en; logic pc_en; logic [1:0] pc_sel; logic reg_wr; logic alu_src;
    logic rd; logic wr; logic b; logic h; logic w; logic [1:0] m2r; logic trap;
  } ctl_t;

  riscv_control_unit #(.DWIDTH(32), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .irOut(irOut), .comparatorOut(comparatorOut),
    .irEn(irEn), .pcEn(pcEn), .pcSelect(pcSelect), .regWrite(regWrite), .aluSrc(aluSrc),
    .ramRdEn(ramRdEn), .ramWrEn(ramWrEn), .isByte(isByte), .isHalf(isHalf), .isWord(isWord),
    .memToReg(memToReg), .trap(trap), .retireCount(retireCount)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic ctl_t observed();
    return {irEn, pcEn, pcSelect, regWrite, aluSrc, ramRdEn, ramWrEn,
            isByte, isHalf, isWord, memToReg, trap};
  endfunction

  function automatic logic is_bad(logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    if (ins == 32'h0) return 1'b1;
    case (ins[6:0])
      7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63: return 1'b0;
      7'h03: return (f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7);
      7'h23: return (f3 > 3'd2);
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit trap_build();
`ifdef CTRL_ILLEGAL_TRAP_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Number of cycles (FETCH included) an instruction occupies.
  function automatic int model_len(logic [31:0] ins);
    if (is_bad(ins)) return 3;
    if (ins[6:0] == 7'h03) return 5;
    if (ins[6:0] == 7'h23) return 4;
    return 3;
  endfunction

  // Expected control word for cycle k (1 = FETCH) of an instruction.
  function automatic ctl_t model(logic [31:0] ins, int k);
    ctl_t c;
    logic [1:0] sz;
    c  = '0;
    sz = ins[13:12];
    if (k == 1) c.ir_en = 1'b1;
    else if (k == 2) c = '0;
    else if (is_bad(ins)) begin
      if (trap_build()) c.trap = 1'b1;
      else c.pc_en = 1'b1;
    end else if (k == 3) begin
      case (ins[6:0])
        7'h33: begin c.reg_wr = 1; c.pc_en = 1; end
        7'h13: begin c.reg_wr = 1; c.pc_en = 1; c.alu_src = 1; end
        7'h37: begin c.reg_wr = 1; c.pc_en = 1; c.m2r = 2'b11; end
        7'h17: begin c.reg_wr = 1; c.pc_en = 1; c.alu_src = 1; end
        7'h6F: begin c.reg_wr = 1; c.pc_en = 1; c.m2r = 2'b10; c.pc_sel = 2'b10; end
        7'h67: begin c.reg_wr = 1; c.pc_en = 1; c.m2r = 2'b10; c.pc_sel = 2'b11; c.alu_src = 1; end
        7'h63: begin c.pc_en = 1; c.pc_sel = 2'b01; end
        default: c.alu_src = 1;
      endcase
    end else begin
      c.alu_src = 1;
      c.b = (sz == 2'd0); c.h = (sz == 2'd1); c.w = (sz == 2'd2);
      if (ins[6:0] == 7'h23) begin c.wr = 1; c.pc_en = 1; end
      else begin
        c.rd = 1;
        if (k == 5) begin c.reg_wr = 1; c.m2r = 2'b01; c.pc_en = 1; end
      end
    end
    return c;
  endfunction

  task automatic check_ctl(input string tag, input ctl_t exp);
    ctl_t obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic check_count(input string tag);
    checks++;
    assert (retireCount === exp_count) else begin
      failures++;
      $error("FAIL %s retireCount got=%0d exp=%0d", tag, retireCount, exp_count);
    end
  endtask

  // Reset low for one edge, then release; DUT is in FETCH afterwards.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check_ctl("reset_outputs_zero", '0);
    @(posedge clk); #1;
    reset = 1'b1;
    exp_count = '0;
    #1;
    check_count("reset_count");
  endtask

  task automatic run_ins(input logic [31:0] ins, input logic cmp);
    int len;
    irOut = ins;
    comparatorOut = cmp;
    if (is_bad(ins) && trap_build()) begin
      for (int k = 1; k <= 22; k++) begin
        check_ctl($sformatf("trap_c%0d", k), model(ins, k));
        if (k >= 3) check_count("trap_frozen");
        @(posedge clk); #1;
      end
      $display("ins %h trapped, recovering by reset", ins);
      do_reset();
      return;
    end
    len = model_len(ins);
    for (int k = 1; k <= len; k++) begin
      check_ctl($sformatf("ins_%h_c%0d", ins, k), model(ins, k));
      @(posedge clk); #1;
    end
    exp_count = exp_count + 1'b1;
    check_count($sformatf("retire_%h", ins));
    $display("ins %h cmp %b cycles %0d retire %0d", ins, cmp, len, retireCount);
  endtask

  function automatic logic [31:0] rand_ins();
    logic [6:0]  ops [9];
    logic [31:0] ins;
    int          r;
    ops = '{7'h33, 7'h13, 7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23};
    r   = $urandom_range(0, 11);
    ins = $urandom();
    if (r < 9) ins[6:0] = ops[r];
    else if (r == 9) ins = 32'h0;
    else ins[6:0] = 7'($urandom_range(0, 127));
    return ins;
  endfunction

  initial begin
    logic [31:0] dir [13];
    dir = '{32'h00108093, 32'h000012B7, 32'h00000297, 32'h000080E7, 32'h00409283,
            32'h00209023, 32'h0020A023, 32'h0040C283, 32'h0040D283, 32'h0040B283,
            32'h0020B023, 32'h0000007F, 32'h00000013};
    reset = 1'b0;
    irOut = 32'h0;
    comparatorOut = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_ctl("reset_state", '0);
    check_count("reset_state_count");
    reset = 1'b1;
    #1;

    run_ins(32'h002081B3, 1'b0);  // ADD
    run_ins(32'h0040A283, 1'b0);  // LW
    run_ins(32'h00208023, 1'b0);  // SB
    run_ins(32'h00208463, 1'b0);  // BEQ not taken
    run_ins(32'h00208463, 1'b1);  // BEQ taken
    run_ins(32'h010000EF, 1'b0);  // JAL
    run_ins(32'h00000000, 1'b0);  // all-zero word
    foreach (dir[i]) run_ins(dir[i], 1'b0);

    // Reset asserted during the MEM cycle of a load aborts it.
    irOut = 32'h0040A283;
    for (int k = 1; k <= 3; k++) begin
      check_ctl($sformatf("abort_lw_c%0d", k), model(32'h0040A283, k));
      @(posedge clk); #1;
    end
    check_ctl("abort_lw_mem", model(32'h0040A283, 4));
    do_reset();
    check_ctl("abort_lw_refetch", model(32'h0040A283, 1));
    $display("ins 0040a283 aborted by reset in MEM, retire %0d", retireCount);

    for (int n = 0; n < 60; n++) run_ins(rand_ins(), 1'($urandom_range(0, 1)));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
